// File: rtl/collision_scanner.sv
// Collision scanner: samples NUM_PROBES points on the player box against the level map, one query per cycle.
// Optional direction flags (grounded/ceiling/wall_l/wall_r) are built when CS_DIR_FLAGS_EN is defined.
module collision_scanner #(
  parameter int POS_W      = 10,
  parameter int NUM_PROBES = 4,
  parameter int PLAYER_W   = 16,
  parameter int PLAYER_H   = 16,
  parameter int MEM_LAT    = 1,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*POS_W-1:0]    player_pos,
  output logic [POS_W-1:0]      query_x,
  output logic [POS_W-1:0]      query_y,
  input  logic                  query_data,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_PROBES-1:0] hit_mask
`ifdef CS_DIR_FLAGS_EN
  ,
  output logic                  grounded,
  output logic                  ceiling,
  output logic                  wall_l,
  output logic                  wall_r
`endif
);

  localparam int IW = $clog2(NUM_PROBES);
  localparam logic [POS_W:0] DX_R = (POS_W+1)'(PLAYER_W - 1);
  localparam logic [POS_W:0] DX_M = (POS_W+1)'(PLAYER_W / 2);
  localparam logic [POS_W:0] DY_B = (POS_W+1)'(PLAYER_H - 1);
  localparam logic [POS_W:0] DY_M = (POS_W+1)'(PLAYER_H / 2);
  localparam logic [POS_W:0] XLIM = (POS_W+1)'(SCREEN_W);
  localparam logic [POS_W:0] YLIM = (POS_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             oob;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } probe_t;

  state_t                state, state_next;
  logic [2*POS_W-1:0]    pos_q;
  logic [IW-1:0]         issue_idx;
  logic                  query_oob;
  logic [NUM_PROBES-1:0] scratch, scratch_next;
  logic [MEM_LAT-1:0]    tag_v;
  logic [MEM_LAT-1:0]    tag_oob;
  logic [IW-1:0]         tag_idx [MEM_LAT];
  logic                  issue_last, last_retire;
  probe_t                first_probe, next_probe;

  // Probe k offset within the box; the extra top bit catches coordinate carry.
  function automatic probe_t probe_at(input logic [2*POS_W-1:0] pos, input logic [IW-1:0] k);
    logic [POS_W:0] dx, dy, x, y;
    probe_t p;
    dx = '0;
    dy = '0;
    case (int'(k))
      1:       dx = DX_R;
      2:       dy = DY_B;
      3:       begin dx = DX_R; dy = DY_B; end
      4:       dx = DX_M;
      5:       begin dx = DX_M; dy = DY_B; end
      6:       dy = DY_M;
      7:       begin dx = DX_R; dy = DY_M; end
      default: ;
    endcase
    x = {1'b0, pos[2*POS_W-1:POS_W]} + dx;
    y = {1'b0, pos[POS_W-1:0]} + dy;
    p.oob = x[POS_W] | y[POS_W] | (x >= XLIM) | (y >= YLIM);
    p.x = x[POS_W-1:0];
    p.y = y[POS_W-1:0];
    return p;
  endfunction

  assign first_probe = probe_at(player_pos, '0);
  assign next_probe  = probe_at(pos_q, issue_idx + IW'(1));
  assign issue_last  = (issue_idx == IW'(NUM_PROBES - 1));
  assign last_retire = tag_v[MEM_LAT-1] && (tag_idx[MEM_LAT-1] == IW'(NUM_PROBES - 1));

  // Out-of-bounds probes ignore the returned data and read as solid.
  always_comb begin
    scratch_next = scratch;
    if (tag_v[MEM_LAT-1])
      scratch_next[tag_idx[MEM_LAT-1]] = tag_oob[MEM_LAT-1] | query_data;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (issue_last) state_next = DRAIN;
      DRAIN:   if (last_retire) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q     <= '0;
      issue_idx <= '0;
      query_x   <= '0;
      query_y   <= '0;
      query_oob <= 1'b0;
      scratch   <= '0;
      hit_mask  <= '0;
      tag_v     <= '0;
      tag_oob   <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_idx[i] <= '0;
    end else begin
      // Tag pipeline mirrors the level read latency so data lines up with its probe.
      tag_v[0]   <= (state == ISSUE);
      tag_idx[0] <= issue_idx;
      tag_oob[0] <= query_oob;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
        tag_oob[i] <= tag_oob[i-1];
      end
      scratch <= scratch_next;
      case (state)
        IDLE: if (start) begin
          pos_q                         <= player_pos;
          {query_oob, query_x, query_y} <= first_probe;
          issue_idx                     <= '0;
          scratch                       <= '0;
        end
        ISSUE: if (!issue_last) begin
          issue_idx                     <= issue_idx + IW'(1);
          {query_oob, query_x, query_y} <= next_probe;
        end
        DRAIN: if (last_retire) hit_mask <= scratch_next;
        default: ;
      endcase
    end
  end

`ifdef CS_DIR_FLAGS_EN
  logic [7:0] m8;
  assign m8 = 8'(scratch_next);

  // Midpoint bits 4..7 are zero-extended away when only corners are probed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grounded <= 1'b0;
      ceiling  <= 1'b0;
      wall_l   <= 1'b0;
      wall_r   <= 1'b0;
    end else if (state == DRAIN && last_retire) begin
      grounded <= m8[2] | m8[3] | m8[5];
      ceiling  <= m8[0] | m8[1] | m8[4];
      wall_l   <= m8[0] | m8[2] | m8[6];
      wall_r   <= m8[1] | m8[3] | m8[7];
    end
  end
`endif

endmodule
